// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage codes and the M/W pipeline register bundle.
package wb_stage_pkg;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC8 = 2'd2;
    localparam logic [1:0] WD_MDU = 2'd3;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_HU = 3'd2;
    localparam logic [2:0] LD_B  = 3'd3;
    localparam logic [2:0] LD_BU = 3'd4;

    localparam logic [31:0] EXC_PC_DEFAULT = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic        reg_we;
        logic [4:0]  a3;
        logic [1:0]  wd_sel;
        logic [31:0] alu_out;
        logic [31:0] mem_rd;
        logic [31:0] mdu_out;
        logic [2:0]  load_type;
    } mw_t;

endpackage

// File: rtl/wb_stage_data_ext.sv
// Load-data extender: selects byte/half from an aligned word and extends it.
module data_ext
    import wb_stage_pkg::*;
(
    input  logic [31:0] mem_rd,
    input  logic [1:0]  off,
    input  logic [2:0]  load_type,
    output logic [31:0] ext
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    always_comb begin
        half = off[1] ? mem_rd[31:16] : mem_rd[15:0];
        unique case (off)
            2'd0:    byte_v = mem_rd[7:0];
            2'd1:    byte_v = mem_rd[15:8];
            2'd2:    byte_v = mem_rd[23:16];
            default: byte_v = mem_rd[31:24];
        endcase
    end

    // Reserved load types fall through to a plain word load.
    always_comb begin
        unique case (load_type)
            LD_H:    ext = {{16{half[15]}}, half};
            LD_HU:   ext = {16'h0000, half};
            LD_B:    ext = {{24{byte_v[7]}}, byte_v};
            LD_BU:   ext = {24'h000000, byte_v};
            default: ext = mem_rd;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: M/W pipeline register, load extension and result select.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] EXC_PC   = EXC_PC_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic [31:0] M_PC,
    input  logic        M_RegWE,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_WDSel,
    input  logic [31:0] M_ALUOut,
    input  logic [31:0] M_MemRD,
    input  logic [31:0] M_MDUOut,
    input  logic [2:0]  M_LoadType,
    output logic        W_WE,
    output logic [4:0]  W_A3,
    output logic [31:0] W_WD,
    output logic [31:0] W_PC,
    output logic        W_FwdValid
);

    mw_t         r;
    logic [31:0] ld_data;
    logic [31:0] pc8;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r    <= '0;
            r.pc <= RESET_PC;
        end else if (Req) begin
            // Bubble: the flushed M instruction must never commit.
            r    <= '0;
            r.pc <= EXC_PC;
        end else begin
            r.pc        <= M_PC;
            r.reg_we    <= M_RegWE;
            r.a3        <= M_A3;
            r.wd_sel    <= M_WDSel;
            r.alu_out   <= M_ALUOut;
            r.mem_rd    <= M_MemRD;
            r.mdu_out   <= M_MDUOut;
            r.load_type <= M_LoadType;
        end
    end

    data_ext u_ext (
        .mem_rd    (r.mem_rd),
        .off       (r.alu_out[1:0]),
        .load_type (r.load_type),
        .ext       (ld_data)
    );

    assign pc8 = r.pc + 32'd8;

    always_comb begin
        unique case (r.wd_sel)
            WD_ALU:  W_WD = r.alu_out;
            WD_MEM:  W_WD = ld_data;
            WD_PC8:  W_WD = pc8;
            default: W_WD = r.mdu_out;
        endcase
    end

    assign W_WE       = r.reg_we && (r.a3 != 5'd0);
    assign W_A3       = r.a3;
    assign W_PC       = r.pc;
    assign W_FwdValid = W_WE;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus random vs. a reference model.
module tb_wb_stage;

    typedef struct packed {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        fwd;
    } wout_t;

    logic        clk = 1'b0;
    logic        reset, req;
    logic [31:0] m_pc, m_alu, m_memrd, m_mdu;
    logic        m_regwe;
    logic [4:0]  m_a3;
    logic [1:0]  m_wdsel;
    logic [2:0]  m_lt;
    logic        w_we, w_fwd;
    logic [4:0]  w_a3;
    logic [31:0] w_wd, w_pc;

    int n_cmp = 0;
    int n_bad = 0;
    wout_t exp_w;
    wout_t act_w;

    always #5 clk = ~clk;

    wb_stage dut (
        .Clk        (clk),
        .Reset      (reset),
        .Req        (req),
        .M_PC       (m_pc),
        .M_RegWE    (m_regwe),
        .M_A3       (m_a3),
        .M_WDSel    (m_wdsel),
        .M_ALUOut   (m_alu),
        .M_MemRD    (m_memrd),
        .M_MDUOut   (m_mdu),
        .M_LoadType (m_lt),
        .W_WE       (w_we),
        .W_A3       (w_a3),
        .W_WD       (w_wd),
        .W_PC       (w_pc),
        .W_FwdValid (w_fwd)
    );

    assign act_w = '{w_we, w_a3, w_wd, w_pc, w_fwd};

    // Load extension from the rules: pick the lane arithmetically, then extend.
    function automatic logic [31:0] load_model(
        input logic [31:0] mem, input int off, input int lt);
        int unsigned b, h;
        b = (mem >> (8 * off)) % 256;
        h = (mem >> (16 * (off / 2))) % 65536;
        case (lt)
            1: return (h >= 32768) ? h - 65536 : h;
            2: return h;
            3: return (b >= 128) ? b - 256 : b;
            4: return b;
            default: return mem;
        endcase
    endfunction

    function automatic wout_t model();
        wout_t e;
        if (reset) begin
            e = '{1'b0, 5'd0, 32'd0, 32'h0, 1'b0};
        end else if (req) begin
            e = '{1'b0, 5'd0, 32'd0, 32'h0000_4180, 1'b0};
        end else begin
            e.we  = m_regwe && (m_a3 != 0);
            e.fwd = e.we;
            e.a3  = m_a3;
            e.pc  = m_pc;
            case (m_wdsel)
                0: e.wd = m_alu;
                1: e.wd = load_model(m_memrd, m_alu % 4, m_lt);
                2: e.wd = m_pc + 8;
                default: e.wd = m_mdu;
            endcase
        end
        return e;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic we,
        input logic [4:0] a3, input logic [1:0] sel, input logic [31:0] alu,
        input logic [31:0] mem, input logic [31:0] mdu, input logic [2:0] lt);
        m_pc = pc; m_regwe = we; m_a3 = a3; m_wdsel = sel;
        m_alu = alu; m_memrd = mem; m_mdu = mdu; m_lt = lt;
    endtask

    task automatic step();
        exp_w = model();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0;
        drive(32'h100, 1'b1, 5'd5, 2'd0, 32'h55, 32'h0, 32'h0, 3'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({w_we, w_a3, w_wd, w_pc, w_fwd} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset[%0d]: got we=%b a3=%0d wd=%h pc=%h fwd=%b, want all 0",
                         i, w_we, w_a3, w_wd, w_pc, w_fwd);
            end
        end
        reset = 1'b0;
        drive(32'h200, 1'b1, 5'd7, 2'd0, 32'hCAFE_0001, 32'h0, 32'h0, 3'd0);
        step();
        n_cmp++;
        if ({w_we, w_a3, w_wd, w_pc} !== {1'b1, 5'd7, 32'hCAFE_0001, 32'h200}) begin
            n_bad++;
            $display("FAIL reset_release: got we=%b a3=%0d wd=%h pc=%h, want 1/7/cafe0001/200",
                     w_we, w_a3, w_wd, w_pc);
        end
    endtask

    task automatic test_alu();
        drive(32'h3000, 1'b1, 5'd8, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 3'd0);
        step();
        n_cmp++;
        if ({w_we, w_a3, w_wd, w_pc, w_fwd} !== {1'b1, 5'd8, 32'h1234_5678, 32'h3000, 1'b1}) begin
            n_bad++;
            $display("FAIL alu: got we=%b a3=%0d wd=%h pc=%h fwd=%b, want 1/8/12345678/3000/1",
                     w_we, w_a3, w_wd, w_pc, w_fwd);
        end
        drive(32'h3004, 1'b1, 5'd9, 2'd3, 32'h0, 32'h0, 32'hA5A5_0F0F, 3'd0);
        step();
        n_cmp++;
        if (w_wd !== 32'hA5A5_0F0F) begin
            n_bad++;
            $display("FAIL mdu: got wd=%h, want a5a50f0f", w_wd);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  lts [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
        logic [1:0]  offs[5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
        logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            drive(32'h4000, 1'b1, 5'd10, 2'd1, {30'h0, offs[i]}, 32'h80FF_7F01, 32'h0, lts[i]);
            step();
            n_cmp++;
            if (w_wd !== exps[i]) begin
                n_bad++;
                $display("FAIL load[lt=%0d off=%0d]: got %h, want %h", lts[i], offs[i], w_wd, exps[i]);
            end
        end
        for (int lt = 0; lt < 8; lt++) begin
            for (int off = 0; off < 4; off++) begin
                drive(32'h4100, 1'b1, 5'd11, 2'd1, {$urandom} & ~32'h3 | off,
                      $urandom, 32'h0, lt[2:0]);
                step();
                n_cmp++;
                if (w_wd !== exp_w.wd) begin
                    n_bad++;
                    $display("FAIL load_sweep[lt=%0d off=%0d]: got %h, want %h", lt, off, w_wd, exp_w.wd);
                end
            end
        end
    endtask

    task automatic test_pc8_wrap();
        drive(32'hFFFF_FFFC, 1'b1, 5'd31, 2'd2, 32'h0, 32'h0, 32'h0, 3'd0);
        step();
        n_cmp++;
        if (w_wd !== 32'h0000_0004) begin
            n_bad++;
            $display("FAIL pc8_wrap: got %h, want 00000004", w_wd);
        end
    endtask

    task automatic test_zero_reg();
        drive(32'h5000, 1'b1, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'd0);
        step();
        n_cmp++;
        if ({w_we, w_fwd} !== 2'b00) begin
            n_bad++;
            $display("FAIL zero_reg: got we=%b fwd=%b, want 0/0", w_we, w_fwd);
        end
    endtask

    task automatic test_req();
        req = 1'b1;
        drive(32'h6000, 1'b1, 5'd9, 2'd0, 32'h1111_2222, 32'h0, 32'h0, 3'd0);
        step();
        n_cmp++;
        if ({w_we, w_a3, w_pc, w_fwd} !== {1'b0, 5'd0, 32'h4180, 1'b0}) begin
            n_bad++;
            $display("FAIL req_bubble: got we=%b a3=%0d pc=%h fwd=%b, want 0/0/4180/0",
                     w_we, w_a3, w_pc, w_fwd);
        end
        req = 1'b0;
        drive(32'h4180, 1'b1, 5'd12, 2'd0, 32'h3333_4444, 32'h0, 32'h0, 3'd0);
        step();
        n_cmp++;
        if ({w_we, w_a3, w_wd, w_pc} !== {1'b1, 5'd12, 32'h3333_4444, 32'h4180}) begin
            n_bad++;
            $display("FAIL req_next: got we=%b a3=%0d wd=%h pc=%h, want 1/12/33334444/4180",
                     w_we, w_a3, w_wd, w_pc);
        end
    endtask

    task automatic test_req_reset();
        req = 1'b1; reset = 1'b1;
        drive(32'h7000, 1'b1, 5'd3, 2'd0, 32'h1, 32'h0, 32'h0, 3'd0);
        step();
        n_cmp++;
        if ({w_we, w_pc} !== {1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL req_reset: got we=%b pc=%h, want 0/00000000", w_we, w_pc);
        end
        req = 1'b0; reset = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(15) == 0);
            req   = ($urandom_range(7) == 0);
            drive($urandom, 1'($urandom), 5'($urandom), 2'($urandom), $urandom,
                  $urandom, $urandom, 3'($urandom));
            step();
            n_cmp++;
            if (act_w !== exp_w) begin
                n_bad++;
                $display("FAIL random[%0d]: got we=%b a3=%0d wd=%h pc=%h fwd=%b, want we=%b a3=%0d wd=%h pc=%h fwd=%b",
                         i, w_we, w_a3, w_wd, w_pc, w_fwd,
                         exp_w.we, exp_w.a3, exp_w.wd, exp_w.pc, exp_w.fwd);
            end
        end
        reset = 1'b0; req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0;
        drive(32'h0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0);
        #2;
        test_reset();
        test_alu();
        test_loads();
        test_pc8_wrap();
        test_zero_reg();
        test_req();
        test_req_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage MIPS pipeline: the M/W pipeline register plus load-data extender and result select.
- Sole driver of the register file write port (WE, A3, WD, PC).
- Also provides the W-stage forwarding source for D/E operand bypass.
- A CP0 request (Req) kills the M-stage instruction so it never commits.

Parameters:
- EXC_PC, 32'h0000_4180: PC carried by a bubble inserted on Req.
- RESET_PC, 32'h0000_0000: W_PC value after reset.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high.
- Req  input  1  exception/interrupt request from CP0; flushes the M instruction.
- M_PC  input  32  PC of the instruction in M.
- M_RegWE  input  1  instruction writes a GPR.
- M_A3  input  5  destination GPR index.
- M_WDSel  input  2  result select: 0=ALU, 1=MEM, 2=PC+8, 3=MDU/CP0.
- M_ALUOut  input  32  ALU result; low 2 bits are the byte offset for loads.
- M_MemRD  input  32  raw aligned word from DM/bridge.
- M_MDUOut  input  32  HI/LO or CP0 read value.
- M_LoadType  input  3  0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu; 5-7 reserved, treated as lw.
- W_WE  output  1  GRF write enable.
- W_A3  output  5  GRF write address.
- W_WD  output  32  GRF write data.
- W_PC  output  32  PC of the W instruction, used for the GRF trace.
- W_FwdValid  output  1  W_WD is a valid forwarding source (W_WE && W_A3!=0).

Behaviour:
- Registered fields: PC, RegWE, A3, WDSel, ALUOut, MemRD, MDUOut, LoadType. All are captured every posedge; the stage has no stall input.
- Reset, which has priority over Req:
  - all fields become 0, PC becomes RESET_PC;
  - W_WE=0, W_A3=0, W_WD=0, W_PC=RESET_PC, W_FwdValid=0 on the cycle after the Reset edge.
- Req=1 (and no Reset):
  - capture a bubble: RegWE=0, A3=0, WDSel=0, data fields 0, PC=EXC_PC;
  - the M instruction never writes the GRF.
- Normal operation: latency is one cycle from M fields to W outputs. W_WD is combinational from registered fields only; there is no combinational path from M inputs to any output.
- W_WE = RegWE && (A3!=0). A write to $0 is never asserted, even if M_RegWE=1.
- W_WD select:
  - WDSel 0 → ALUOut.
  - WDSel 1 → extended load data.
  - WDSel 2 → PC+8, mod 2^32 (wraps).
  - WDSel 3 → MDUOut.
- Load extension uses off = ALUOut[1:0].
  - lw: MemRD.
  - lh/lhu: half = off[1] ? MemRD[31:16] : MemRD[15:0]; off[0] is ignored because misalignment is trapped upstream. Sign-extend for lh, zero-extend for lhu.
  - lb/lbu: byte = MemRD[8*off+7 : 8*off]. Sign-extend for lb, zero-extend for lbu.
- Mid-pipeline Reset discards the held instruction with no write. A Reset deasserted the same cycle a valid M instruction is presented captures that instruction normally on the next edge.

Decomposition:
- Shared macro.v holds:
  - WDSel codes: WD_ALU, WD_MEM, WD_PC8, WD_MDU;
  - LoadType codes: LD_W, LD_H, LD_HU, LD_B, LD_BU;
  - EXC_PC default value.
- One sub-module, data_ext: purely combinational (MemRD, off, LoadType) → 32-bit extended word. It is instantiated once inside wb_stage and reused by tests in isolation.

Test Plan:
- Reset held 2 cycles with M_RegWE=1, M_A3=5 → W_WE=0, W_A3=0, W_WD=0, W_PC=0 throughout.
- M: RegWE=1, A3=8, WDSel=0, ALUOut=32'h1234_5678, PC=32'h3000 → next cycle W_WE=1, W_A3=8, W_WD=32'h1234_5678, W_PC=32'h3000, W_FwdValid=1.
- MemRD=32'h80FF_7F01, WDSel=1, sweep each load type over ALUOut[1:0] → required W_WD:
  - lb off=3 → 32'hFFFF_FF80;
  - lbu off=1 → 32'h0000_007F;
  - lh off=2 → 32'hFFFF_80FF;
  - lhu off=0 → 32'h0000_7F01;
  - lw → 32'h80FF_7F01.
- WDSel=2 with PC=32'hFFFF_FFFC → W_WD=32'h0000_0004 (wrap).
- RegWE=1, A3=0, ALUOut=32'hDEAD_BEEF → W_WE=0, W_FwdValid=0.
- Req=1 while M holds RegWE=1, A3=9 → next cycle W_WE=0, W_A3=0, W_PC=32'h4180. The following valid instruction commits normally.
- Req=1 and Reset=1 together → W_PC=0 (Reset wins).
